// File: rtl/mem_op_pkg.sv
// Shared types and constants for the indexed/amend memory-operation sequencer.
package mem_op_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEL_1,
    SEL_2,
    SEL_3,
    RD_DATA,
    MEM_REQ,
    WB,
    DONE
  } state_t;

  localparam logic OP_IDX   = 1'b0;
  localparam logic OP_AMEND = 1'b1;

  localparam logic [1:0] MEM_READ  = 2'b00;
  localparam logic [1:0] MEM_WRITE = 2'b01;

  // The wait counter never holds more than limit-1, so size it for that.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/mem_op_fsm_if.sv
// Request, register-file and memory signals of mem_op_fsm, bundled for port use.
interface mem_op_fsm_if #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_SEL_W = 3
);

  logic                 start;
  logic                 op;
  logic [REG_SEL_W-1:0] reg_a;
  logic [REG_SEL_W-1:0] reg_b;
  logic [REG_SEL_W-1:0] reg_c;
  logic [DATA_W-1:0]    reg_out_bus;
  logic [DATA_W-1:0]    mem_data_out_bus;
  logic                 mem_ready;

  logic [REG_SEL_W-1:0] reg_sel;
  logic                 reg_mode;
  logic [DATA_W-1:0]    reg_data;
  logic [DATA_W-1:0]    mem_address;
  logic [DATA_W-1:0]    mem_offset;
  logic [DATA_W-1:0]    mem_data;
  logic [1:0]           mem_mode;
  logic                 mem_req;
  logic                 busy;
  logic                 finished;
  logic                 err;

  modport slave (
    input  start, op, reg_a, reg_b, reg_c, reg_out_bus, mem_data_out_bus, mem_ready,
    output reg_sel, reg_mode, reg_data, mem_address, mem_offset, mem_data,
           mem_mode, mem_req, busy, finished, err
  );

  modport master (
    output start, op, reg_a, reg_b, reg_c, reg_out_bus, mem_data_out_bus, mem_ready,
    input  reg_sel, reg_mode, reg_data, mem_address, mem_offset, mem_data,
           mem_mode, mem_req, busy, finished, err
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; expired fires on the TIMEOUT-th wait cycle (never if TIMEOUT is 0).
module mem_wait_timer
  import mem_op_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic r_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Combinational so the abort lands on the same edge the count would reach TIMEOUT.
  assign expired = (TIMEOUT != 0) && count_en && (count == LAST);

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_op_fsm.sv
// Sequencer for indexed load (a <- (b)[c]) and amend store ((a)[b] <- c) through a shared register file.
module mem_op_fsm
  import mem_op_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_SEL_W = 3,
  parameter int unsigned TIMEOUT   = 16
) (
  input logic          clk,
  input logic          r_n,
  mem_op_fsm_if.slave  bus
);

  state_t               state;
  logic                 op_q;
  logic [REG_SEL_W-1:0] a_q;
  logic [REG_SEL_W-1:0] b_q;
  logic [REG_SEL_W-1:0] c_q;

  logic [REG_SEL_W-1:0] reg_sel_q;
  logic                 reg_mode_q;
  logic [DATA_W-1:0]    reg_data_q;
  logic [DATA_W-1:0]    addr_q;
  logic [DATA_W-1:0]    off_q;
  logic [DATA_W-1:0]    data_q;
  logic [1:0]           mem_mode_q;
  logic                 mem_req_q;
  logic                 busy_q;
  logic                 finished_q;
  logic                 err_q;

  logic is_idx;
  logic tmr_clear;
  logic tmr_en;
  logic tmr_expired;

  assign is_idx    = (op_q == OP_IDX);
  assign tmr_clear = (state != MEM_REQ);
  assign tmr_en    = (state == MEM_REQ) && !bus.mem_ready;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .r_n      (r_n),
    .clear    (tmr_clear),
    .count_en (tmr_en),
    .expired  (tmr_expired)
  );

  // Outputs are loaded on entry to the state that presents them.
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      state      <= IDLE;
      op_q       <= OP_IDX;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      reg_sel_q  <= '0;
      reg_mode_q <= 1'b0;
      reg_data_q <= '0;
      addr_q     <= '0;
      off_q      <= '0;
      data_q     <= '0;
      mem_mode_q <= MEM_READ;
      mem_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      reg_mode_q <= 1'b0;
      finished_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q      <= bus.op;
            a_q       <= bus.reg_a;
            b_q       <= bus.reg_b;
            c_q       <= bus.reg_c;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            reg_sel_q <= (bus.op == OP_IDX) ? bus.reg_b : bus.reg_a;
            state     <= SEL_1;
          end
        end
        SEL_1: begin
          reg_sel_q <= is_idx ? c_q : b_q;
          state     <= SEL_2;
        end
        SEL_2: begin
          addr_q    <= bus.reg_out_bus;
          reg_sel_q <= c_q;
          state     <= SEL_3;
        end
        SEL_3: begin
          off_q <= bus.reg_out_bus;
          if (is_idx) begin
            mem_req_q  <= 1'b1;
            mem_mode_q <= MEM_READ;
            state      <= MEM_REQ;
          end else begin
            state <= RD_DATA;
          end
        end
        RD_DATA: begin
          data_q     <= bus.reg_out_bus;
          mem_req_q  <= 1'b1;
          mem_mode_q <= MEM_WRITE;
          state      <= MEM_REQ;
        end
        MEM_REQ: begin
          // A ready on the expiring cycle still counts as success: the timer only counts non-ready cycles.
          if (bus.mem_ready) begin
            mem_req_q <= 1'b0;
            if (is_idx) begin
              reg_data_q <= bus.mem_data_out_bus;
              reg_sel_q  <= a_q;
              reg_mode_q <= 1'b1;
              state      <= WB;
            end else begin
              finished_q <= 1'b1;
              state      <= DONE;
            end
          end else if (tmr_expired) begin
            mem_req_q  <= 1'b0;
            err_q      <= 1'b1;
            finished_q <= 1'b1;
            state      <= DONE;
          end
        end
        WB: begin
          finished_q <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.reg_sel     = reg_sel_q;
  assign bus.reg_mode    = reg_mode_q;
  assign bus.reg_data    = reg_data_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_offset  = off_q;
  assign bus.mem_data    = data_q;
  assign bus.mem_mode    = mem_mode_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.busy        = busy_q;
  assign bus.finished    = finished_q;
  assign bus.err         = err_q;

endmodule

// File: doc/mem_op_fsm.md
MEM_OP_FSM -- requirements
Module: mem_op_fsm

Interface
REQ-001 Parameter DATA_W, default 32: register, address, offset and memory data width.
REQ-002 Parameter REG_SEL_W, default 3: register-select width.
REQ-003 Parameter TIMEOUT, default 16: maximum MEM_REQ cycles without mem_ready before error; 0 disables the timeout.
REQ-004 clk  in  1  single clock; all state changes on posedge.
REQ-005 r_n  in  1  reset; asynchronous, active-low.
REQ-006 start  in  1  one-cycle request; sampled only in IDLE.
REQ-007 op  in  1  0 = OP_IDX (a <- (b)[c]), 1 = OP_AMEND ((a)[b] <- c); captured with start.
REQ-008 reg_a, reg_b, reg_c  in  REG_SEL_W each  operand register numbers; captured with start.
REQ-009 reg_out_bus  in  DATA_W  register-file read data; valid the cycle after reg_sel is driven.
REQ-010 mem_data_out_bus  in  DATA_W  memory read data; valid while mem_ready=1.
REQ-011 mem_ready  in  1  memory completion strobe for the current request.
REQ-012 reg_sel  out  REG_SEL_W  register-file select.
REQ-013 reg_mode  out  1  1 = write reg_data to reg_sel this cycle.
REQ-014 reg_data  out  DATA_W  register write data.
REQ-015 mem_address, mem_offset, mem_data  out  DATA_W each  memory request fields.
REQ-016 mem_mode  out  2  MEM_READ = 2'b00, MEM_WRITE = 2'b01.
REQ-017 mem_req  out  1  memory request valid.
REQ-018 busy  out  1  1 in every state except IDLE.
REQ-019 finished  out  1  one-cycle completion pulse.
REQ-020 err  out  1  qualifies finished; 1 = timeout abort.

Function
REQ-021 States: IDLE, SEL_1, SEL_2, SEL_3, RD_DATA, MEM_REQ, WB, DONE.
REQ-022 IDLE: start=1 captures op and reg_a/b/c, then -> SEL_1; otherwise stay in IDLE.
REQ-023 SEL_1: reg_sel = reg_b (IDX) or reg_a (AMEND); -> SEL_2.
REQ-024 SEL_2: latch mem_address <= reg_out_bus; reg_sel = reg_c (IDX) or reg_b (AMEND); -> SEL_3.
REQ-025 SEL_3: latch mem_offset <= reg_out_bus; reg_sel = reg_c; IDX -> MEM_REQ, AMEND -> RD_DATA.
REQ-026 RD_DATA: latch mem_data <= reg_out_bus; -> MEM_REQ.
REQ-027 MEM_REQ: mem_req=1; mem_mode = MEM_READ (IDX) or MEM_WRITE (AMEND); address, offset and data are held stable.
REQ-028 MEM_REQ, mem_ready=1: IDX latches rdata <= mem_data_out_bus and goes -> WB; AMEND goes -> DONE.
REQ-029 MEM_REQ wait counter: increments each cycle mem_ready=0; when TIMEOUT!=0 and count reaches TIMEOUT, -> DONE with err latched to 1 and no writeback.
REQ-030 mem_ready=1 on the same cycle the count reaches TIMEOUT: success; no error.
REQ-031 WB: reg_mode=1, reg_sel=reg_a, reg_data=rdata; -> DONE.
REQ-032 DONE: finished=1 for exactly one cycle; -> IDLE; err stays valid until the next start.
REQ-033 reg_mode=1 only in WB; mem_req=1 only in MEM_REQ; mem_ready outside MEM_REQ is ignored.
REQ-034 start while busy is ignored and not queued.
REQ-035 start in the same cycle as finished is ignored (state is DONE, not IDLE).
REQ-036 Latency without wait states: IDX 6 cycles start-to-finished, AMEND 6 cycles; each mem_ready wait cycle adds 1.
REQ-037 reg_a == reg_b == reg_c is legal; IDX writes back the read data.

Reset
REQ-038 r_n=0 asynchronously forces state IDLE and clears all outputs, latched fields and the wait counter to 0.
REQ-039 Reset during MEM_REQ drops mem_req immediately without waiting for clk; the aborted operation never asserts finished.

Structure
REQ-040 Shared package mem_op_pkg holds the state enum, OP_IDX/OP_AMEND and MEM_READ/MEM_WRITE constants.
REQ-041 Wait counter is sub-module mem_wait_timer (parameter TIMEOUT; ports clk, r_n, clear, count_en, expired).

Verification
REQ-042 IDX, r2=0x100, r3=0x4, mem_ready on first MEM_REQ cycle returns 0xDEADBEEF -> address 0x100, offset 0x4, r1 written 0xDEADBEEF, finished 6 cycles after start, err=0.
REQ-043 AMEND, r1=0x200, r2=0x8, r3=0x12345678 -> one MEM_WRITE request with those fields, reg_mode never 1, finished, err=0.
REQ-044 IDX with mem_ready delayed 5 cycles -> mem_req high 6 cycles with fields stable; finished at cycle 11.
REQ-045 TIMEOUT=4, mem_ready never asserted -> mem_req high 4 cycles, finished with err=1, no register write.
REQ-046 r_n pulsed low mid-MEM_REQ -> mem_req drops asynchronously; next start completes normally.
REQ-047 start asserted while busy and again on the finished cycle -> both ignored; exactly one finished pulse.
